// File: rtl/eth_hdr_classifier.sv
// Ethernet header classifier: decodes DMAC, source port and ethertype of each first beat, queues results in a fall-through FIFO.
// Optional macro ETH_CLASSIFIER_VLAN_EN enables 802.1Q tag decoding (VLAN id plus inner ethertype).
module eth_hdr_classifier #(
  parameter int C_S_AXIS_TDATA_WIDTH = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 4,
  parameter int DEPTH_BITS           = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] i_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0] i_tuser,
  input  logic                            i_word1,
  input  logic [48*NUM_PORTS-1:0]         i_macs,
  output logic                            o_res_valid,
  input  logic                            i_res_ready,
  output logic                            o_is_for_us,
  output logic                            o_is_bmcast,
  output logic                            o_is_bcast,
  output logic                            o_is_ipv4,
  output logic                            o_is_arp,
  output logic                            o_is_ipv6,
  output logic                            o_from_cpu,
  output logic                            o_bad_port,
  output logic [1:0]                      o_port_idx,
  output logic                            o_vlan_valid,
  output logic [11:0]                     o_vlan_id,
  output logic                            o_overflow,
  output logic [31:0]                     o_pkt_cnt,
  output logic [31:0]                     o_drop_cnt
);

`ifdef ETH_CLASSIFIER_VLAN_EN
  localparam int RES_W = 23;
`else
  localparam int RES_W = 10;
`endif
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

  logic [47:0] dmac;
  logic [15:0] etype;
  logic [7:0]  sport;
  logic [15:0] type_eff;
  logic [3:0]  ones;
  logic [2:0]  bit_idx;
  logic [1:0]  port_k;
  logic        bad, odd, mac_match, bmcast, bcast;
  logic        vlan_valid;
  logic [11:0] vlan_id;
  logic [RES_W-1:0] cls, s1_res, head;
  logic        s1_valid;
  logic        unused_bits;

  assign dmac  = i_tdata[255:208];
  assign etype = i_tdata[159:144];
  assign sport = i_tuser[23:16];
  assign unused_bits = ^{i_tdata, i_tuser};

  // Source port decode: even bit 2k is MAC port k, odd bit 2k+1 is CPU port k.
  always_comb begin
    ones    = 4'd0;
    bit_idx = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (sport[b]) begin
        ones    = ones + 4'd1;
        bit_idx = 3'(b);
      end
    end
    port_k = bit_idx[2:1];
    odd    = bit_idx[0];
    bad    = (ones != 4'd1) || ({30'd0, port_k} >= NUM_PORTS);
    mac_match = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_k == 2'(p) && dmac == i_macs[48*p +: 48])
        mac_match = 1'b1;
    end
  end

  assign bmcast = dmac[40];
  assign bcast  = (dmac == 48'hFFFF_FFFF_FFFF);

`ifdef ETH_CLASSIFIER_VLAN_EN
  assign vlan_valid = (etype == 16'h8100);
  assign vlan_id    = vlan_valid ? i_tdata[139:128] : 12'd0;
  assign type_eff   = vlan_valid ? i_tdata[127:112] : etype;
`else
  assign vlan_valid = 1'b0;
  assign vlan_id    = 12'd0;
  assign type_eff   = etype;
`endif

  always_comb begin
    cls = '0;
    cls[9] = ~bad & ~odd & (bmcast | mac_match);
    cls[8] = bmcast;
    cls[7] = bcast;
    cls[6] = (type_eff == 16'h0800);
    cls[5] = (type_eff == 16'h0806);
    cls[4] = (type_eff == 16'h86DD);
    cls[3] = ~bad & odd;
    cls[2] = bad;
    cls[1:0] = bad ? 2'd0 : port_k;
`ifdef ETH_CLASSIFIER_VLAN_EN
    cls[22:10] = {vlan_valid, vlan_id};
`endif
  end

  // Stage S1: classification registered the cycle after the first beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
    end else begin
      s1_valid <= i_word1;
      if (i_word1)
        s1_res <= cls;
    end
  end

  logic [RES_W-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  full, pop, push_ok;

  assign full        = (count == FULL_CNT);
  assign o_res_valid = (count != '0);
  assign pop         = o_res_valid & i_res_ready;
  assign push_ok     = s1_valid & (~full | pop);

  // Result FIFO plus drop/packet statistics; a refused push is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
      o_pkt_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      o_overflow <= s1_valid & ~push_ok;
      if (s1_valid && o_pkt_cnt != 32'hFFFF_FFFF)
        o_pkt_cnt <= o_pkt_cnt + 32'd1;
      if (s1_valid && !push_ok && o_drop_cnt != 32'hFFFF_FFFF)
        o_drop_cnt <= o_drop_cnt + 32'd1;
      if (push_ok) begin
        mem[wr_ptr] <= s1_res;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = o_res_valid ? mem[rd_ptr] : '0;

  assign o_is_for_us = head[9];
  assign o_is_bmcast = head[8];
  assign o_is_bcast  = head[7];
  assign o_is_ipv4   = head[6];
  assign o_is_arp    = head[5];
  assign o_is_ipv6   = head[4];
  assign o_from_cpu  = head[3];
  assign o_bad_port  = head[2];
  assign o_port_idx  = head[1:0];
`ifdef ETH_CLASSIFIER_VLAN_EN
  assign o_vlan_valid = head[22];
  assign o_vlan_id    = head[21:10];
`else
  assign o_vlan_valid = 1'b0;
  assign o_vlan_id    = 12'd0;
`endif

endmodule

// File: tb/tb_eth_hdr_classifier.sv
// Directed self-checking bench for eth_hdr_classifier (NUM_PORTS=2, DEPTH_BITS=2).
module tb_eth_hdr_classifier;

  localparam logic [47:0] MAC0  = 48'h0200_0000_0010;
  localparam logic [47:0] MAC1  = 48'h0200_0000_0011;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] OTHER = 48'h02AA_BBCC_DDEE;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] i_tdata;
  logic [127:0] i_tuser;
  logic         i_word1;
  logic [95:0]  i_macs;
  logic         o_res_valid, i_res_ready;
  logic         o_is_for_us, o_is_bmcast, o_is_bcast, o_is_ipv4, o_is_arp, o_is_ipv6;
  logic         o_from_cpu, o_bad_port, o_vlan_valid, o_overflow;
  logic [1:0]   o_port_idx;
  logic [11:0]  o_vlan_id;
  logic [31:0]  o_pkt_cnt, o_drop_cnt;
  logic [22:0]  sig;

  int total = 0;
  int bad   = 0;

  eth_hdr_classifier #(
    .C_S_AXIS_TDATA_WIDTH(256), .C_S_AXIS_TUSER_WIDTH(128), .NUM_PORTS(2), .DEPTH_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tuser(i_tuser), .i_word1(i_word1),
    .i_macs(i_macs), .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
    .o_is_for_us(o_is_for_us), .o_is_bmcast(o_is_bmcast), .o_is_bcast(o_is_bcast),
    .o_is_ipv4(o_is_ipv4), .o_is_arp(o_is_arp), .o_is_ipv6(o_is_ipv6),
    .o_from_cpu(o_from_cpu), .o_bad_port(o_bad_port), .o_port_idx(o_port_idx),
    .o_vlan_valid(o_vlan_valid), .o_vlan_id(o_vlan_id), .o_overflow(o_overflow),
    .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  // All result outputs packed into one word for compact comparisons.
  assign sig = {o_is_for_us, o_is_bmcast, o_is_bcast, o_is_ipv4, o_is_arp, o_is_ipv6,
                o_from_cpu, o_bad_port, o_port_idx, o_vlan_valid, o_vlan_id};

  task automatic drive_beat(input logic [47:0] dmac, input logic [15:0] etype,
                            input logic [7:0] sport, input logic [15:0] tci,
                            input logic [15:0] inner);
    i_tdata = '0;
    i_tdata[255:208] = dmac;
    i_tdata[159:144] = etype;
    i_tdata[143:128] = tci;
    i_tdata[127:112] = inner;
    i_tuser = '0;
    i_tuser[23:16] = sport;
    i_word1 = 1'b1;
    @(posedge clk); #1;
    i_word1 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (o_res_valid !== 1'b0 || o_overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags valid=%b ovf=%b expected 0 0", o_res_valid, o_overflow);
    end
    total++;
    if (o_pkt_cnt !== 32'd0 || o_drop_cnt !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_cnt pkt=%0d drop=%0d expected 0 0", o_pkt_cnt, o_drop_cnt);
    end
    total++;
    if (sig !== 23'h0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got=%h expected 000000", sig);
    end
  endtask

  task automatic test_for_us();
    i_res_ready = 1'b1;
    drive_beat(MAC1, 16'h0800, 8'h04, 16'h0, 16'h0);
    total++;
    if (o_res_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL for_us_early valid=%b expected 0", o_res_valid);
    end
    idle(1);
    total++;
    if (o_res_valid !== 1'b1 || sig !== 23'h482000) begin
      bad++;
      $display("[TB] FAIL for_us_result valid=%b got=%h expected 1 482000", o_res_valid, sig);
    end
    idle(1);
    total++;
    if (o_res_valid !== 1'b0 || sig !== 23'h0) begin
      bad++;
      $display("[TB] FAIL for_us_popped valid=%b got=%h expected 0 000000", o_res_valid, sig);
    end
  endtask

  task automatic test_bcast();
    i_res_ready = 1'b1;
    drive_beat(BCAST, 16'h0806, 8'h01, 16'h0, 16'h0);
    idle(1);
    total++;
    if (o_res_valid !== 1'b1 || sig !== 23'h740000) begin
      bad++;
      $display("[TB] FAIL bcast_result valid=%b got=%h expected 1 740000", o_res_valid, sig);
    end
    idle(1);
  endtask

  task automatic test_cpu();
    i_res_ready = 1'b1;
    drive_beat(MAC0, 16'h0800, 8'h02, 16'h0, 16'h0);
    idle(1);
    total++;
    if (o_res_valid !== 1'b1 || sig !== 23'h090000) begin
      bad++;
      $display("[TB] FAIL cpu_result valid=%b got=%h expected 1 090000", o_res_valid, sig);
    end
    idle(1);
  endtask

  task automatic test_bad_port();
    i_res_ready = 1'b0;
    drive_beat(MAC0, 16'h0800, 8'h05, 16'h0, 16'h0);
    drive_beat(BCAST, 16'h0806, 8'h40, 16'h0, 16'h0);
    idle(1);
    total++;
    if (o_res_valid !== 1'b1 || sig !== 23'h088000) begin
      bad++;
      $display("[TB] FAIL bad_port_05 valid=%b got=%h expected 1 088000", o_res_valid, sig);
    end
    i_res_ready = 1'b1;
    idle(1);
    total++;
    if (o_res_valid !== 1'b1 || sig !== 23'h348000) begin
      bad++;
      $display("[TB] FAIL bad_port_40 valid=%b got=%h expected 1 348000", o_res_valid, sig);
    end
    idle(1);
    total++;
    if (o_res_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bad_port_drain valid=%b expected 0", o_res_valid);
    end
    i_res_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [22:0] exp_q [4];
    int ovf_cycles;
    exp_q[0] = 23'h080000;
    exp_q[1] = 23'h042000;
    exp_q[2] = 23'h030000;
    exp_q[3] = 23'h012000;
    do_reset();
    i_res_ready = 1'b0;
    ovf_cycles = 0;
    drive_beat(OTHER, 16'h0800, 8'h01, 16'h0, 16'h0);
    if (o_overflow === 1'b1) ovf_cycles++;
    drive_beat(OTHER, 16'h0806, 8'h04, 16'h0, 16'h0);
    if (o_overflow === 1'b1) ovf_cycles++;
    drive_beat(OTHER, 16'h86DD, 8'h02, 16'h0, 16'h0);
    if (o_overflow === 1'b1) ovf_cycles++;
    drive_beat(OTHER, 16'h1234, 8'h08, 16'h0, 16'h0);
    if (o_overflow === 1'b1) ovf_cycles++;
    drive_beat(OTHER, 16'h0800, 8'h01, 16'h0, 16'h0);
    if (o_overflow === 1'b1) ovf_cycles++;
    drive_beat(OTHER, 16'h0800, 8'h01, 16'h0, 16'h0);
    if (o_overflow === 1'b1) ovf_cycles++;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (o_overflow === 1'b1) ovf_cycles++;
    end
    total++;
    if (ovf_cycles != 2) begin
      bad++;
      $display("[TB] FAIL ovf_pulses got=%0d expected 2", ovf_cycles);
    end
    total++;
    if (o_pkt_cnt !== 32'd6 || o_drop_cnt !== 32'd2) begin
      bad++;
      $display("[TB] FAIL ovf_counts pkt=%0d drop=%0d expected 6 2", o_pkt_cnt, o_drop_cnt);
    end
    i_res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (o_res_valid !== 1'b1 || sig !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL ovf_order[%0d] valid=%b got=%h expected 1 %h", i, o_res_valid, sig, exp_q[i]);
      end
      idle(1);
    end
    total++;
    if (o_res_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovf_drain valid=%b expected 0", o_res_valid);
    end
    i_res_ready = 1'b0;
  endtask

  task automatic test_vlan();
    logic [22:0] exp_sig;
`ifdef ETH_CLASSIFIER_VLAN_EN
    exp_sig = 23'h421123;
`else
    exp_sig = 23'h400000;
`endif
    i_res_ready = 1'b1;
    drive_beat(MAC0, 16'h8100, 8'h01, 16'h0123, 16'h86DD);
    idle(1);
    total++;
    if (o_res_valid !== 1'b1 || sig !== exp_sig) begin
      bad++;
      $display("[TB] FAIL vlan_result valid=%b got=%h expected 1 %h", o_res_valid, sig, exp_sig);
    end
    idle(1);
    i_res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_res_ready = 1'b0;
    drive_beat(OTHER, 16'h0800, 8'h01, 16'h0, 16'h0);
    drive_beat(OTHER, 16'h0806, 8'h04, 16'h0, 16'h0);
    drive_beat(OTHER, 16'h86DD, 8'h01, 16'h0, 16'h0);
    drive_beat(OTHER, 16'h0800, 8'h04, 16'h0, 16'h0);
    reset   = 1'b1;
    i_word1 = 1'b1;
    idle(1);
    reset   = 1'b0;
    i_word1 = 1'b0;
    total++;
    if (o_res_valid !== 1'b0 || o_pkt_cnt !== 32'd0 || o_drop_cnt !== 32'd0 || o_overflow !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset valid=%b pkt=%0d drop=%0d ovf=%b expected 0 0 0 0",
               o_res_valid, o_pkt_cnt, o_drop_cnt, o_overflow);
    end
    i_res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      total++;
      if (o_res_valid !== 1'b0 || o_pkt_cnt !== 32'd0) begin
        bad++;
        $display("[TB] FAIL mid_reset_stale[%0d] valid=%b pkt=%0d expected 0 0", i, o_res_valid, o_pkt_cnt);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    i_tdata     = '0;
    i_tuser     = '0;
    i_word1     = 1'b0;
    i_res_ready = 1'b0;
    i_macs      = {MAC1, MAC0};
    #1;
    test_reset();
    test_for_us();
    test_bcast();
    test_cpu();
    test_bad_port();
    test_overflow();
    test_vlan();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/eth_hdr_classifier.md
ETH_HDR_CLASSIFIER -- requirements
Module: eth_hdr_classifier

Interface
REQ-001 SHALL have parameter C_S_AXIS_TDATA_WIDTH, 256, data bus width; only 256 is supported.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, 128, sideband width; source-port byte at [23:16].
REQ-003 SHALL have parameter NUM_PORTS, 4, number of MAC ports, legal 1..4.
REQ-004 SHALL have parameter DEPTH_BITS, 2, result FIFO depth = 2**DEPTH_BITS entries.
REQ-005 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: i_tdata  in  256  packet data; i_tuser  in  128  sideband; i_word1  in  1  first beat of packet present and accepted this cycle.
REQ-007 SHALL have port i_macs  in  48*NUM_PORTS  port MACs, port k at [48k+47:48k].
REQ-008 SHALL have ports: o_res_valid  out  1; i_res_ready  in  1; result popped when both high.
REQ-009 SHALL have result outputs (1 bit each unless stated): o_is_for_us, o_is_bmcast, o_is_bcast, o_is_ipv4, o_is_arp, o_is_ipv6, o_from_cpu, o_bad_port, o_port_idx (2), o_vlan_valid, o_vlan_id (12).
REQ-010 SHALL have ports: o_overflow  out  1  drop pulse; o_pkt_cnt  out  32; o_drop_cnt  out  32.

Function
REQ-011 SHALL decode fields: dmac = i_tdata[255:208], ethertype = i_tdata[159:144], sport = i_tuser[23:16].
REQ-012 SHALL treat sport even bit 2k as MAC port k, odd bit 2k+1 as CPU port k; o_port_idx = k.
REQ-013 SHALL set o_bad_port when sport is not exactly one-hot or k >= NUM_PORTS; then for_us=0, port_idx=0.
REQ-014 SHALL set o_from_cpu for a valid odd bit; for_us=0 for CPU-sourced packets.
REQ-015 SHALL set o_is_bmcast = dmac[40]; o_is_bcast = (dmac == 48'hFFFFFFFFFFFF); for MAC-port packets for_us = bmcast OR (dmac == MAC of port k).
REQ-016 SHALL classify ethertype (inner when VLAN-tagged): 0x0800 ipv4, 0x0806 arp, 0x86DD ipv6; at most one set, none for others.
REQ-017 SHALL register classification in the cycle after i_word1 (stage S1) and push it to FIFO at end of S1; o_res_valid high no earlier than 2 cycles after i_word1.
REQ-018 SHALL present FIFO head combinationally (fall-through); outputs hold until popped.
REQ-019 SHALL accept push when FIFO not full, or when full and a pop occurs same cycle.
REQ-020 SHALL, when push is refused, discard result, pulse o_overflow one cycle, increment o_drop_cnt.
REQ-021 SHALL increment o_pkt_cnt on every S1 push attempt (accepted or dropped).
REQ-022 SHALL saturate both counters at 32'hFFFFFFFF.
REQ-023 SHALL ignore i_res_ready when FIFO empty; no pointer movement.
REQ-024 SHALL handle i_word1 on back-to-back cycles, one result per word1, in order.
REQ-025 SHALL drive all result outputs 0 while o_res_valid is 0.

Reset
REQ-026 SHALL, on reset, empty FIFO, cancel S1 result, clear counters; o_res_valid=0, o_overflow=0.
REQ-027 SHALL ignore i_word1 asserted in the reset cycle; result for a word1 one cycle before reset is lost.

Configuration
REQ-028 SHALL support macro ETH_CLASSIFIER_VLAN_EN: when defined, ethertype 0x8100 sets o_vlan_valid, o_vlan_id = i_tdata[139:128], inner ethertype = i_tdata[127:112]; FIFO width grows by 13 bits.
REQ-029 SHALL, when ETH_CLASSIFIER_VLAN_EN undefined, tie o_vlan_valid and o_vlan_id to 0 and classify 0x8100 as none of ipv4/arp/ipv6.

Verification
REQ-030 SHALL cover: sport=8'h04, dmac = i_macs port 1, ethertype 0x0800, ready=1 -> after 2 cycles valid with for_us=1, ipv4=1, port_idx=1.
REQ-031 SHALL cover: sport=8'h01, dmac FF:FF:FF:FF:FF:FF, ethertype 0x0806 -> bmcast=1, bcast=1, for_us=1, arp=1.
REQ-032 SHALL cover: sport=8'h05 and sport=8'h40 with NUM_PORTS=2 -> bad_port=1, for_us=0 for both.
REQ-033 SHALL cover: DEPTH_BITS=2, ready=0, 6 back-to-back word1 -> 4 results held, o_overflow pulsed twice, drop_cnt=2, pkt_cnt=6; then ready=1 -> 4 results popped in order.
REQ-034 SHALL cover: VLAN_EN defined, ethertype 0x8100, TCI 16'h0123, inner 0x86DD -> vlan_valid=1, vlan_id=12'h123, ipv6=1; undefined -> vlan_valid=0, all type flags 0.
REQ-035 SHALL cover: reset asserted with 3 entries queued and word1 in S1 -> next cycle valid=0, counters 0, no stale result emerges.
